// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// bounce_generator : emulates a bouncing push-button for debouncer stimulus
// Rev 1.0 - initial release
// ============================================================================
module bounce_generator #(
  parameter int unsigned N_BOUNCE   = 4,
  parameter int unsigned GAP_W      = 3,
  parameter int unsigned RANDOM     = 1,
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic btn_out,
  output logic busy,
  output logic done
);

  localparam logic [7:0]     C_SEED      = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [4:0]     C_TOGGLES   = 5'(2 * N_BOUNCE + 1);
  localparam logic [7:0]     C_SETTLE    = 8'(SETTLE_CYC);
  localparam logic [GAP_W:0] C_GAP_ONE   = {{GAP_W{1'b0}}, 1'b1};
  localparam logic [GAP_W:0] C_FIXED_GAP = {1'b1, {GAP_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [GAP_W:0] gap_q, gap_d;
  logic [4:0]     tog_q, tog_d;
  logic [7:0]     settle_q, settle_d;
  logic           btn_q, btn_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [GAP_W:0] new_gap;

  generate
    if (RANDOM != 0) begin : g_random_gap
      assign new_gap = {1'b0, lfsr_q[GAP_W-1:0]} + C_GAP_ONE;
    end else begin : g_fixed_gap
      assign new_gap = C_FIXED_GAP;
    end
  endgenerate

  // x^8+x^6+x^5+x^4+1; a non-zero seed can never reach the all-zero state
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tog_d    = tog_q;
    settle_d = settle_q;
    btn_d    = btn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_in != btn_q) begin
          state_d = S_BOUNCE;
          busy_d  = 1'b1;
          gap_d   = new_gap;
          tog_d   = C_TOGGLES;
        end
      end
      S_BOUNCE: begin
        if (gap_q > C_GAP_ONE) begin
          gap_d = gap_q - C_GAP_ONE;
        end else begin
          btn_d = ~btn_q;
          tog_d = tog_q - 5'd1;
          if (tog_q == 5'd1) begin
            state_d  = S_SETTLE;
            settle_d = C_SETTLE;
            gap_d    = '0;
          end else begin
            gap_d = new_gap;
          end
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (settle_q == 8'd1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= C_SEED;
      gap_q    <= '0;
      tog_q    <= '0;
      settle_q <= '0;
      btn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      gap_q    <= gap_d;
      tog_q    <= tog_d;
      settle_q <= settle_d;
      btn_q    <= btn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign btn_out = btn_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// tb_bounce_generator : event scoreboard for three bounce_generator configs
// Rev 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

  localparam logic [7:0] B_SEED = 8'hA5;
  localparam logic [1:0] K_DONE = 2'd0, K_FALL = 2'd1, K_START = 2'd2, K_TOG = 2'd3;

  typedef struct {
    int         cyc;
    logic [1:0] dut;
    logic [1:0] kind;
    logic       val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lvl_a = 1'b0, lvl_b = 1'b0, lvl_c = 1'b0;
  logic btn_a, busy_a, done_a;
  logic btn_b, busy_b, done_b;
  logic btn_b2, busy_b2, done_b2;
  logic btn_c, busy_c, done_c;
  logic [2:0] btn_w, busy_w, done_w;
  logic [2:0] prev_btn = 3'b000, prev_busy = 3'b000;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int last_b = 0;
  int tog_cnt_b = 0;
  int k;
  logic [7:0] lfsr_m = B_SEED;
  ev_t q[$];

  assign btn_w  = {btn_c, btn_b, btn_a};
  assign busy_w = {busy_c, busy_b, busy_a};
  assign done_w = {done_c, done_b, done_a};

  always #5 clk = ~clk;

  bounce_generator #(.N_BOUNCE(2), .GAP_W(2), .RANDOM(0), .SEED(8'hA5), .SETTLE_CYC(8)) u_a (
    .clk(clk), .rst(rst), .level_in(lvl_a), .btn_out(btn_a), .busy(busy_a), .done(done_a));
  bounce_generator #(.N_BOUNCE(4), .GAP_W(3), .RANDOM(1), .SEED(B_SEED), .SETTLE_CYC(8)) u_b (
    .clk(clk), .rst(rst), .level_in(lvl_b), .btn_out(btn_b), .busy(busy_b), .done(done_b));
  bounce_generator #(.N_BOUNCE(4), .GAP_W(3), .RANDOM(1), .SEED(B_SEED), .SETTLE_CYC(8)) u_b2 (
    .clk(clk), .rst(rst), .level_in(lvl_b), .btn_out(btn_b2), .busy(busy_b2), .done(done_b2));
  bounce_generator #(.N_BOUNCE(0), .GAP_W(1), .RANDOM(0), .SEED(8'h00), .SETTLE_CYC(3)) u_c (
    .clk(clk), .rst(rst), .level_in(lvl_c), .btn_out(btn_c), .busy(busy_c), .done(done_c));

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push_ev(input int cyc, input int dut, input logic [1:0] kind, input logic val);
    ev_t e;
    e.cyc  = cyc;
    e.dut  = 2'(dut);
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  // Predict one full burst; fixed_gap==0 means gaps come from the LFSR model,
  // whose current value is the one the DUT uses at edge k.
  task automatic push_burst(input int dut, input int kk, input int nt, input int fixed_gap,
                            input int gw, input int settle, input logic start_btn);
    logic [7:0] l;
    int e;
    int g;
    logic b;
    l = lfsr_m;
    e = kk;
    b = start_btn;
    push_ev(kk, dut, K_START, 1'b1);
    for (int t = 0; t < nt; t++) begin
      if (fixed_gap != 0) g = fixed_gap;
      else g = 1 + int'(l & 8'((1 << gw) - 1));
      for (int j = 0; j < g; j++) l = lfsr_step(l);
      e += g;
      b = ~b;
      push_ev(e, dut, K_TOG, b);
    end
    push_ev(e + settle, dut, K_DONE, 1'b1);
    push_ev(e + settle, dut, K_FALL, 1'b0);
  endtask

  task automatic got(input int dut, input logic [1:0] kind, input logic val);
    ev_t x;
    checks++;
    assert (q.size() != 0) else begin
      failures++;
      $error("FAIL ev_unexpected dut=%0d kind=%0d val=%0d at edge %0d, expected none", dut, kind, val, edge_n);
    end
    if (q.size() == 0) return;
    x = q.pop_front();
    chk("ev_dut_kind_val", 32'({2'(dut), kind, val}), 32'({x.dut, x.kind, x.val}));
    chk("ev_cycle", 32'(edge_n), 32'(x.cyc));
  endtask

  task automatic observe();
    for (int d = 0; d < 3; d++) begin
      if (done_w[d]) begin
        got(d, K_DONE, 1'b1);
        if (d == 1) begin
          chk("b_toggles_per_burst", 32'(tog_cnt_b), 32'd9);
          chk("b_settled_level", 32'(btn_w[1]), 32'(lvl_b));
        end
      end
      if (prev_busy[d] && !busy_w[d]) got(d, K_FALL, 1'b0);
      if (!prev_busy[d] && busy_w[d]) begin
        got(d, K_START, 1'b1);
        if (d == 1) begin
          last_b = edge_n;
          tog_cnt_b = 0;
        end
      end
      if (btn_w[d] !== prev_btn[d]) begin
        got(d, K_TOG, btn_w[d]);
        if (d == 1) begin
          chk("b_gap_in_1_to_8", 32'((edge_n - last_b) >= 1 && (edge_n - last_b) <= 8), 32'd1);
          last_b = edge_n;
          tog_cnt_b++;
        end
      end
    end
    chk("b_same_seed_trace", 32'(btn_b2), 32'(btn_b));
    prev_btn  = btn_w;
    prev_busy = busy_w;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      lfsr_m = rst ? B_SEED : lfsr_step(lfsr_m);
      #1;
      observe();
    end
  endtask

  task automatic run_until_empty(input int max_cyc);
    int c;
    c = 0;
    while (q.size() != 0 && c < max_cyc) begin
      step(1);
      c++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    step(2);
    chk("reset_outputs", 32'({btn_w, busy_w, done_w}), 32'd0);
    rst = 1'b0;
    step(2);
    chk("idle_outputs", 32'({btn_w, busy_w, done_w}), 32'd0);

    // 0->1 then 1->0 on the fixed-gap instance
    lvl_a = 1'b1; k = edge_n + 1;
    push_burst(0, k, 5, 4, 2, 8, 1'b0);
    run_until_empty(60);
    chk("a_level_after_rise", 32'(btn_a), 32'd1);
    step(3);
    lvl_a = 1'b0; k = edge_n + 1;
    push_burst(0, k, 5, 4, 2, 8, 1'b1);
    run_until_empty(60);
    chk("a_level_after_fall", 32'(btn_a), 32'd0);
    step(3);

    // Short pulse while busy: burst completes to 1, then a second burst back to 0
    lvl_a = 1'b1; k = edge_n + 1;
    push_burst(0, k, 5, 4, 2, 8, 1'b0);
    push_burst(0, k + 29, 5, 4, 2, 8, 1'b1);
    step(2);
    lvl_a = 1'b0;
    run_until_empty(100);
    chk("a_level_after_pulse", 32'(btn_a), 32'd0);
    step(3);

    // Single-toggle instance
    lvl_c = 1'b1; k = edge_n + 1;
    push_burst(2, k, 1, 2, 1, 3, 1'b0);
    run_until_empty(20);
    step(2);
    lvl_c = 1'b0; k = edge_n + 1;
    push_burst(2, k, 1, 2, 1, 3, 1'b1);
    run_until_empty(20);
    step(2);

    // Asynchronous reset in the middle of a burst, level_in held high
    lvl_a = 1'b1; k = edge_n + 1;
    push_burst(0, k, 5, 4, 2, 8, 1'b0);
    step(13);
    chk("a_btn_before_reset", 32'(btn_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_btn", 32'(btn_a), 32'd0);
    chk("async_reset_busy", 32'(busy_a), 32'd0);
    chk("async_reset_done", 32'(done_a), 32'd0);
    q.delete();
    lfsr_m    = B_SEED;
    prev_btn  = btn_w;
    prev_busy = busy_w;
    step(2);
    rst = 1'b0; k = edge_n + 1;
    push_burst(0, k, 5, 4, 2, 8, 1'b0);
    run_until_empty(60);
    step(3);

    // Random-gap instance: 200 transitions
    for (int t = 0; t < 200; t++) begin
      step(int'($urandom_range(0, 3)));
      lvl_b = ~lvl_b; k = edge_n + 1;
      push_burst(1, k, 9, 0, 3, 8, ~lvl_b);
      run_until_empty(200);
    end
    step(5);
    chk("final_scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
